pipeline_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RISC-V core.
- Drives the fetch stage's stall, flush, pc_sel and jmp_addr inputs, plus the ID/EX bubble and EX-hold controls.
- Resolves load-use hazards, branch/jump redirects, multi-cycle WOS accelerator instructions (start/done handshake with timeout) and program halt.
- Sits between decode/execute status signals and the pipeline registers.

---
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch redirects, WOS accelerator wait, halt.
// Latency: all control outputs are combinational (same cycle); state, counters, error flag registered.
// Backpressure: holds fetch/ID (stall) and ID/EX+EX/MEM (hold_ex) while waiting on the accelerator.
module pipeline_ctrl #(
  parameter int ACC_TIMEOUT = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_wos_op,
  input  logic             acc_done,
  input  logic             halt_req,
  output logic             pc_sel,
  output logic [31:0]      jmp_addr,
  output logic             stall,
  output logic             flush,
  output logic             bubble_ex,
  output logic             hold_ex,
  output logic             acc_start,
  output logic             acc_error,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (ACC_TIMEOUT > 1) ? $clog2(ACC_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACC_TIMEOUT - 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_ACC_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              acc_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic load_use, wait_expired;
  logic pc_sel_c, flush_c, stall_c, bubble_c, hold_c, start_c;

  // Load in EX feeding a source register of the ID instruction (x0 never hazards).
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  assign wait_expired = (wait_q == WAIT_LAST);

  // Next-state and control decode; branch outranks everything because it squashes ID.
  always_comb begin
    state_d  = state_q;
    pc_sel_c = 1'b0;
    flush_c  = 1'b0;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    hold_c   = 1'b0;
    start_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          pc_sel_c = 1'b1;
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (halt_req) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = ST_HALT;
        end else if (ex_wos_op) begin
          start_c = 1'b1;
          stall_c = 1'b1;
          hold_c  = 1'b1;
          state_d = ST_ACC_WAIT;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      ST_ACC_WAIT: begin
        // EX is frozen, so its branch/halt status is stale and ignored here.
        if (acc_done || wait_expired) begin
          state_d = ST_RUN;
        end else begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
        end
      end
      ST_HALT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, accelerator wait counter, sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      acc_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ACC_WAIT && !wait_expired) wait_q <= wait_q + WAIT_W'(1);
      else                                         wait_q <= '0;
      if (state_q == ST_ACC_WAIT && wait_expired && !acc_done) acc_err_q <= 1'b1;
    end
  end

  // Saturating count of cycles in which fetch was stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  // Reset forces every output low, including the otherwise pass-through target.
  assign pc_sel    = pc_sel_c & ~rst;
  assign flush     = flush_c  & ~rst;
  assign stall     = stall_c  & ~rst;
  assign bubble_ex = bubble_c & ~rst;
  assign hold_ex   = hold_c   & ~rst;
  assign acc_start = start_c  & ~rst;
  assign acc_error = acc_err_q & ~rst;
  assign halted    = (state_q == ST_HALT) & ~rst;
  assign jmp_addr  = rst ? 32'd0 : ex_target;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a tiny fetch PC model driven by the controller.
// Latency: checks combinational outputs 1-2 ns after each rising edge.
// Backpressure: fetch PC holds on stall, loads jmp_addr on pc_sel.
module tb_pipeline_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic [31:0] ex_target;
  logic ex_wos_op, acc_done, halt_req;
  logic pc_sel, stall, flush, bubble_ex, hold_ex, acc_start, acc_error, halted;
  logic [31:0] jmp_addr;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  logic [31:0] pc;
  logic [31:0] pc_save;
  logic [7:0] obs;

  pipeline_ctrl #(.ACC_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_target(ex_target), .ex_wos_op(ex_wos_op), .acc_done(acc_done), .halt_req(halt_req),
    .pc_sel(pc_sel), .jmp_addr(jmp_addr), .stall(stall), .flush(flush),
    .bubble_ex(bubble_ex), .hold_ex(hold_ex), .acc_start(acc_start),
    .acc_error(acc_error), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Order: pc_sel stall flush bubble_ex hold_ex acc_start acc_error halted
  assign obs = {pc_sel, stall, flush, bubble_ex, hold_ex, acc_start, acc_error, halted};

  // Fetch model: redirect wins, otherwise advance unless stalled.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'd0;
    else if (pc_sel) pc <= jmp_addr;
    else if (!stall) pc <= pc + 32'd4;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_target = 32'd0;
    ex_wos_op = 1'b0; acc_done = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1'b1;
    ex_target = 32'hDEAD_BEEF; halt_req = 1'b1; ex_wos_op = 1'b1; ex_branch_taken = 1'b1;
    #2;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL reset_ctrl: got %b want %b", obs, 8'b0); end
    total++; if (jmp_addr !== 32'd0) begin bad++; $display("FAIL reset_jmp: got %h want %h", jmp_addr, 32'd0); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    clr_in();
    rst = 1'b0;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL reset_release: got %b want %b", obs, 8'b0); end
  endtask

  task automatic test_load_use();
    next_cycle(); clr_in();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    total++; if (obs !== 8'b0101_0000) begin bad++; $display("FAIL lu_rs1: got %b want %b", obs, 8'b0101_0000); end
    exp_cnt++;
    pc_save = pc;
    next_cycle(); clr_in();
    #1;
    total++; if (pc !== pc_save) begin bad++; $display("FAIL lu_pc_hold: got %h want %h", pc, pc_save); end
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL lu_one_cycle: got %b want %b", obs, 8'b0); end
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    next_cycle();
    total++; if (pc !== pc_save + 32'd4) begin bad++; $display("FAIL lu_pc_adv: got %h want %h", pc, pc_save + 32'd4); end
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL lu_x0: got %b want %b", obs, 8'b0); end
    next_cycle(); clr_in();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #1;
    total++; if (obs !== 8'b0101_0000) begin bad++; $display("FAIL lu_rs2: got %b want %b", obs, 8'b0101_0000); end
    exp_cnt++;
    next_cycle(); clr_in();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL lu_unused: got %b want %b", obs, 8'b0); end
    ex_mem_read = 1'b0; id_uses_rs1 = 1'b1;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL lu_not_load: got %b want %b", obs, 8'b0); end
    next_cycle(); clr_in();
    #1;
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_cnt2: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_branch();
    next_cycle(); clr_in();
    ex_branch_taken = 1'b1; ex_target = 32'h40;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    halt_req = 1'b1; ex_wos_op = 1'b1;
    #1;
    total++; if (obs !== 8'b1011_0000) begin bad++; $display("FAIL br_ctrl: got %b want %b", obs, 8'b1011_0000); end
    total++; if (jmp_addr !== 32'h40) begin bad++; $display("FAIL br_target: got %h want %h", jmp_addr, 32'h40); end
    next_cycle(); clr_in();
    #1;
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL br_fetch_pc: got %h want %h", pc, 32'h40); end
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL br_stay_run: got %b want %b", obs, 8'b0); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL br_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_accel();
    next_cycle(); clr_in();
    ex_wos_op = 1'b1;
    #1;
    total++; if (obs !== 8'b0100_1100) begin bad++; $display("FAIL acc_start: got %b want %b", obs, 8'b0100_1100); end
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      ex_branch_taken = 1'b1; halt_req = 1'b1; ex_target = 32'h100;
      #1;
      total++; if (obs !== 8'b0100_1000) begin bad++; $display("FAIL acc_wait%0d: got %b want %b", i, obs, 8'b0100_1000); end
    end
    next_cycle();
    acc_done = 1'b1;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL acc_done: got %b want %b", obs, 8'b0); end
    exp_cnt += 8;
    next_cycle(); clr_in();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    #1;
    total++; if (obs !== 8'b0101_0000) begin bad++; $display("FAIL acc_recheck: got %b want %b", obs, 8'b0101_0000); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL acc_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    exp_cnt++;
    next_cycle(); clr_in();
    acc_done = 1'b1;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL acc_done_run: got %b want %b", obs, 8'b0); end
    next_cycle(); clr_in();
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL acc_done_run2: got %b want %b", obs, 8'b0); end
  endtask

  task automatic test_timeout();
    next_cycle(); clr_in();
    ex_wos_op = 1'b1;
    #1;
    total++; if (obs !== 8'b0100_1100) begin bad++; $display("FAIL to_start: got %b want %b", obs, 8'b0100_1100); end
    for (int i = 0; i < TO - 1; i++) begin
      next_cycle();
      #1;
      total++; if (obs !== 8'b0100_1000) begin bad++; $display("FAIL to_wait%0d: got %b want %b", i, obs, 8'b0100_1000); end
    end
    next_cycle();
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL to_release: got %b want %b", obs, 8'b0); end
    exp_cnt += TO;
    next_cycle(); clr_in();
    #1;
    total++; if (obs !== 8'b0000_0010) begin bad++; $display("FAIL to_error: got %b want %b", obs, 8'b0000_0010); end
    total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL to_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    repeat (3) next_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2; id_uses_rs1 = 1'b1;
    #1;
    total++; if (obs !== 8'b0101_0010) begin bad++; $display("FAIL to_sticky: got %b want %b", obs, 8'b0101_0010); end
  endtask

  task automatic test_reset_acc();
    next_cycle(); clr_in();
    ex_wos_op = 1'b1; ex_target = 32'h1234;
    repeat (4) next_cycle();
    rst = 1'b1;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL racc_outs: got %b want %b", obs, 8'b0); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL racc_cnt: got %0d want 0", stall_cnt); end
    total++; if (jmp_addr !== 32'd0) begin bad++; $display("FAIL racc_jmp: got %h want %h", jmp_addr, 32'd0); end
    next_cycle(); clr_in();
    rst = 1'b0;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL racc_release: got %b want %b", obs, 8'b0); end
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
    #1;
    total++; if (obs !== 8'b0101_0000) begin bad++; $display("FAIL racc_run: got %b want %b", obs, 8'b0101_0000); end
    next_cycle(); clr_in();
    #1;
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL racc_cnt2: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_halt();
    next_cycle(); clr_in();
    halt_req = 1'b1;
    #1;
    total++; if (obs !== 8'b0101_0000) begin bad++; $display("FAIL halt_req: got %b want %b", obs, 8'b0101_0000); end
    next_cycle(); clr_in();
    ex_branch_taken = 1'b1; ex_target = 32'h80; ex_wos_op = 1'b1;
    #1;
    pc_save = pc;
    for (int i = 0; i < 4; i++) begin
      total++; if (obs !== 8'b0101_0001) begin bad++; $display("FAIL halt_hold%0d: got %b want %b", i, obs, 8'b0101_0001); end
      next_cycle();
      #1;
    end
    total++; if (pc !== pc_save) begin bad++; $display("FAIL halt_pc: got %h want %h", pc, pc_save); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL halt_async_rst: got %b want %b", obs, 8'b0); end
    next_cycle(); clr_in();
    rst = 1'b0;
    #1;
    total++; if (obs !== 8'b0) begin bad++; $display("FAIL halt_after_rst: got %b want %b", obs, 8'b0); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_accel();
    test_timeout();
    test_reset_acc();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
